// File: rtl/window_coeff_sequencer.sv
// Stages window coefficients from the settings bus into a local RAM, then on a
// load command waits for a packet boundary, stalls samples and streams the set.
// Ports:
//   clk, reset                        ce_clk domain, synchronous active-high reset
//   set_stb/set_addr/set_data         settings bus (coeff address, coeff data, load)
//   i_t*                              sample stream in
//   o_t*                              sample stream out to the windowing core
//   m_axis_coeff_t*                   coefficient stream to the windowing core
//   busy, load_count, err_count       status
module window_coeff_sequencer #(
  parameter logic [7:0] SR_COEFF_ADDR           = 8'd132,
  parameter logic [7:0] SR_COEFF_DATA           = 8'd133,
  parameter logic [7:0] SR_LOAD                 = 8'd134,
  parameter int         MAX_LOG2_OF_WINDOW_SIZE = 12,
  parameter int         COEFF_WIDTH             = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   set_stb,
  input  logic [7:0]             set_addr,
  input  logic [31:0]            set_data,
  input  logic [31:0]            i_tdata,
  input  logic                   i_tlast,
  input  logic                   i_tvalid,
  output logic                   i_tready,
  output logic [31:0]            o_tdata,
  output logic                   o_tlast,
  output logic                   o_tvalid,
  input  logic                   o_tready,
  output logic [COEFF_WIDTH-1:0] m_axis_coeff_tdata,
  output logic                   m_axis_coeff_tlast,
  output logic                   m_axis_coeff_tvalid,
  input  logic                   m_axis_coeff_tready,
  output logic                   busy,
  output logic [15:0]            load_count,
  output logic [15:0]            err_count
);

  localparam int AW = MAX_LOG2_OF_WINDOW_SIZE;
  localparam logic [AW:0] DEPTH_L = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_L = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ONE_P = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_STREAM
  } state_t;

  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] rd_idx_q, rd_idx_d;
  logic in_packet_q, in_packet_d;
  logic vld_q, vld_d;
  logic last_q, last_d;
  logic [15:0] load_cnt_q, load_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic [COEFF_WIDTH-1:0] ram [1 << AW];
  logic [COEFF_WIDTH-1:0] rd_data_q;

  logic is_addr, is_data, is_load;
  logic [AW:0] load_len;
  logic len_ok, pass_en, beat, hs;
  logic rd_en, wr_en, err;
  logic unused_bits;

  assign unused_bits = ^set_data;

  assign is_addr = set_stb & (set_addr == SR_COEFF_ADDR);
  assign is_data = set_stb & (set_addr == SR_COEFF_DATA);
  assign is_load = set_stb & (set_addr == SR_LOAD);
  assign load_len = set_data[AW:0];
  assign len_ok = (load_len != '0) & (load_len <= DEPTH_L);

  assign pass_en = (state_q == S_IDLE) |
                   ((state_q == S_DRAIN) & in_packet_q);
  assign beat = i_tvalid & o_tready & pass_en;
  assign hs = vld_q & m_axis_coeff_tready;

  // Prefetch the next coeff whenever the output register is empty or
  // is being consumed this cycle; this keeps back-to-back throughput.
  assign rd_en = (state_q == S_STREAM) & (rd_idx_q != len_q) &
                 (~vld_q | m_axis_coeff_tready);

  assign o_tdata = i_tdata;
  assign o_tlast = i_tlast;
  assign o_tvalid = i_tvalid & pass_en;
  assign i_tready = o_tready & pass_en;

  assign m_axis_coeff_tdata = rd_data_q;
  assign m_axis_coeff_tvalid = vld_q;
  assign m_axis_coeff_tlast = last_q;
  assign busy = (state_q != S_IDLE);
  assign load_count = load_cnt_q;
  assign err_count = err_cnt_q;

  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    len_d = len_q;
    rd_idx_d = rd_idx_q;
    in_packet_d = in_packet_q;
    vld_d = vld_q;
    last_d = last_q;
    load_cnt_d = load_cnt_q;
    err_cnt_d = err_cnt_q;
    wr_en = 1'b0;
    err = 1'b0;

    if (is_addr) wr_ptr_d = set_data[AW-1:0];

    if (is_data) begin
      if (state_q == S_IDLE) begin
        wr_en = 1'b1;
        wr_ptr_d = wr_ptr_q + ONE_P;
      end else begin
        err = 1'b1;
      end
    end

    if (is_load) begin
      if ((state_q == S_IDLE) & len_ok) begin
        len_d = load_len;
        rd_idx_d = '0;
        state_d = S_DRAIN;
      end else begin
        err = 1'b1;
      end
    end

    if (beat) in_packet_d = ~i_tlast;

    unique case (state_q)
      S_DRAIN: begin
        // Once the tlast beat clears in_packet the path is closed
        // for one cycle here before the stream starts.
        if (!in_packet_q) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (rd_en) begin
          rd_idx_d = rd_idx_q + ONE_L;
          vld_d = 1'b1;
          last_d = (rd_idx_q == len_q - ONE_L);
        end else if (hs) begin
          vld_d = 1'b0;
        end
        if (hs & last_q) begin
          vld_d = 1'b0;
          last_d = 1'b0;
          load_cnt_d = load_cnt_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    if (err & (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wr_ptr_q <= '0;
      len_q <= '0;
      rd_idx_q <= '0;
      in_packet_q <= 1'b0;
      vld_q <= 1'b0;
      last_q <= 1'b0;
      load_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      len_q <= len_d;
      rd_idx_q <= rd_idx_d;
      in_packet_q <= in_packet_d;
      vld_q <= vld_d;
      last_q <= last_d;
      load_cnt_q <= load_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Staging RAM: contents survive reset; only one port is active at a
  // time because writes are accepted in IDLE and reads happen in STREAM.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr_q] <= set_data[COEFF_WIDTH-1:0];
    if (rd_en) rd_data_q <= ram[rd_idx_q[AW-1:0]];
  end

endmodule

// File: tb/tb_window_coeff_sequencer.sv
// Directed bench for window_coeff_sequencer: staging, packet-boundary drain,
// coeff streaming with backpressure, command rejection, pointer wrap, reset abort.
module tb_window_coeff_sequencer;

  localparam logic [7:0] A_ADDR = 8'd132;
  localparam logic [7:0] A_DATA = 8'd133;
  localparam logic [7:0] A_LOAD = 8'd134;

  logic clk = 1'b0;
  logic reset;
  logic set_stb;
  logic [7:0] set_addr;
  logic [31:0] set_data;
  logic [31:0] i_tdata;
  logic i_tlast, i_tvalid, i_tready;
  logic [31:0] o_tdata;
  logic o_tlast, o_tvalid, o_tready;
  logic [15:0] c_tdata;
  logic c_tlast, c_tvalid, c_tready;
  logic busy;
  logic [15:0] load_count, err_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] f_v, l_v;

  always #5 clk = ~clk;

  window_coeff_sequencer dut (
    .clk(clk),
    .reset(reset),
    .set_stb(set_stb),
    .set_addr(set_addr),
    .set_data(set_data),
    .i_tdata(i_tdata),
    .i_tlast(i_tlast),
    .i_tvalid(i_tvalid),
    .i_tready(i_tready),
    .o_tdata(o_tdata),
    .o_tlast(o_tlast),
    .o_tvalid(o_tvalid),
    .o_tready(o_tready),
    .m_axis_coeff_tdata(c_tdata),
    .m_axis_coeff_tlast(c_tlast),
    .m_axis_coeff_tvalid(c_tvalid),
    .m_axis_coeff_tready(c_tready),
    .busy(busy),
    .load_count(load_count),
    .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sreg(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1;
    set_addr = a;
    set_data = d;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic collect(input int n, input logic [15:0] base,
                         input bit tog, input bit cv,
                         output logic [15:0] first_v,
                         output logic [15:0] last_v);
    int k;
    int cyc;
    bit pst;
    logic [17:0] pv;
    k = 0;
    cyc = 0;
    pst = 1'b0;
    pv = '0;
    first_v = '0;
    last_v = '0;
    while (k < n && cyc < n * 3 + 20) begin
      c_tready = tog ? ((cyc % 2) == 0) : 1'b1;
      #1;
      if (pst) chk("stall_hold", {14'd0, c_tvalid, c_tlast, c_tdata},
                   {14'd0, 1'b1, pv[16], pv[15:0]});
      if (!tog && k > 0) chk("no_bubble", c_tvalid, 1);
      if (c_tvalid && c_tready) begin
        if (k == 0) first_v = c_tdata;
        last_v = c_tdata;
        if (cv) chk("coeff", c_tdata, base + k[15:0]);
        chk("coeff_last", c_tlast, (k == n - 1));
        k++;
      end
      pst = c_tvalid && !c_tready;
      pv = {1'b0, c_tlast, c_tdata};
      tick();
      cyc++;
    end
    c_tready = 1'b1;
    chk("coeff_count", k, n);
  endtask

  initial begin
    reset = 1'b1;
    set_stb = 1'b0;
    set_addr = '0;
    set_data = '0;
    i_tdata = '0;
    i_tlast = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    c_tready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cvalid", c_tvalid, 0);
    chk("rst_load", load_count, 0);
    chk("rst_err", err_count, 0);
    chk("rst_irdy", i_tready, 1);

    // 1: stage 1..8 and stream with idle input
    sreg(A_ADDR, 0);
    for (int i = 1; i <= 8; i++) sreg(A_DATA, i);
    sreg(A_LOAD, 8);
    chk("t1_busy", busy, 1);
    chk("t1_v_drain", c_tvalid, 0);
    tick();
    chk("t1_v_first", c_tvalid, 0);
    chk("t1_stall", i_tready, 0);
    tick();
    chk("t1_v_second", c_tvalid, 1);
    chk("t1_d0", c_tdata, 16'd1);
    collect(8, 16'd1, 1'b0, 1'b1, f_v, l_v);
    chk("t1_load", load_count, 1);
    chk("t1_idle", busy, 0);
    chk("t1_irdy", i_tready, 1);

    // 2: load mid packet, drain remaining beats, stream, resume
    for (int b = 0; b < 16; b++) begin
      i_tvalid = 1'b1;
      i_tdata = 32'h1000 + b;
      i_tlast = (b == 15);
      set_stb = (b == 5);
      set_addr = A_LOAD;
      set_data = 4;
      #1;
      chk("t2_pass_v", o_tvalid, 1);
      chk("t2_pass_d", o_tdata, 32'h1000 + b);
      chk("t2_busy", busy, (b > 5));
      tick();
    end
    set_stb = 1'b0;
    i_tdata = 32'h2000;
    i_tlast = 1'b1;
    #1;
    chk("t2_gate_v", o_tvalid, 0);
    chk("t2_gate_r", i_tready, 0);
    collect(4, 16'd1, 1'b0, 1'b1, f_v, l_v);
    chk("t2_resume_v", o_tvalid, 1);
    chk("t2_resume_d", o_tdata, 32'h2000);
    chk("t2_resume_r", i_tready, 1);
    chk("t2_load", load_count, 2);
    tick();
    i_tvalid = 1'b0;
    i_tlast = 1'b0;

    // 3: rejected commands and writes
    sreg(A_ADDR, 0);
    sreg(A_LOAD, 0);
    sreg(A_LOAD, 4097);
    chk("t3_err2", err_count, 2);
    chk("t3_notbusy", busy, 0);
    sreg(A_LOAD, 2);
    sreg(A_LOAD, 3);
    sreg(A_DATA, 32'hDEAD);
    chk("t3_err4", err_count, 4);
    collect(2, 16'd1, 1'b0, 1'b1, f_v, l_v);
    sreg(A_DATA, 32'h55);
    sreg(A_LOAD, 1);
    collect(1, 16'h55, 1'b0, 1'b1, f_v, l_v);
    chk("t3_err_final", err_count, 4);
    chk("t3_load", load_count, 4);

    // 4: 256 coeffs with tready toggling
    sreg(A_ADDR, 0);
    for (int i = 0; i < 256; i++) sreg(A_DATA, i);
    sreg(A_LOAD, 256);
    collect(256, 16'd0, 1'b1, 1'b1, f_v, l_v);
    chk("t4_load", load_count, 5);

    // 5: write pointer wrap and full-depth load
    sreg(A_ADDR, 4095);
    sreg(A_DATA, 32'hAAAA);
    sreg(A_DATA, 32'hBBBB);
    sreg(A_LOAD, 4096);
    collect(4096, 16'd0, 1'b0, 1'b0, f_v, l_v);
    chk("t5_first", f_v, 16'hBBBB);
    chk("t5_last", l_v, 16'hAAAA);
    chk("t5_load", load_count, 6);

    // 6: reset in the middle of a stream
    sreg(A_ADDR, 0);
    for (int i = 0; i < 8; i++) sreg(A_DATA, 32'h60 + i);
    sreg(A_LOAD, 8);
    repeat (4) tick();
    chk("t6_mid_d", c_tdata, 16'h62);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_cvalid", c_tvalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_load", load_count, 0);
    chk("t6_err", err_count, 0);
    sreg(A_LOAD, 8);
    collect(8, 16'h60, 1'b0, 1'b1, f_v, l_v);
    chk("t6_load_after", load_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
